mem_responder: RTL and testbench

- Data-side responder serving the load/store requests that the multicycle controller issues (special/load, special/stor).
- Accepts one request at a time over a valid/ready handshake and applies a programmable number of wait states.
- Returns a single-cycle response pulse.
- Backs a word-addressed RAM plus a small memory-mapped I/O window (LED register, switch input, cycle counter) at the top of the address space.

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_ram_array.sv | 32 +++
 rtl/mem_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-side memory responder: FSM states, access
// classes, I/O window offsets and the default I/O base address.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_RAM   = 3'd0,
    SEL_LED   = 3'd1,
    SEL_SW    = 3'd2,
    SEL_CNT   = 3'd3,
    SEL_UNMAP = 3'd4
  } sel_e;

  localparam logic [3:0]  IO_LED          = 4'd0;
  localparam logic [3:0]  IO_SW           = 4'd1;
  localparam logic [3:0]  IO_CNT          = 4'd2;
  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFF0;

endpackage

// File: rtl/mem_ram_array.sv
// Single-port-style RAM array: synchronous write, registered read.
// No reset on the storage or read register so it maps onto block RAM.
module mem_ram_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // storage write and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Load/store responder: one request at a time, programmable wait states,
// single-cycle registered response; RAM plus an I/O window (LED, switches, counter).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter int               DATA_W      = 16,
  parameter int               DEPTH       = 256,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam int RAM_AW  = $clog2(DEPTH);
  localparam int WC_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WC_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IO_SPAN  = ADDR_W'(16);
  localparam logic [WC_W-1:0]   WC_LOAD  = WC_W'(WC_INIT);
  localparam logic [WC_W-1:0]   WC_ZERO  = {WC_W{1'b0}};
  localparam logic [WC_W-1:0]   WC_ONE   = WC_W'(1'b1);
  localparam logic [DATA_W-1:0] CNT_ONE  = DATA_W'(1'b1);
  localparam logic [DATA_W-1:0] DATA_Z   = {DATA_W{1'b0}};
  localparam logic [DATA_W-9:0] EXT_Z    = {(DATA_W-8){1'b0}};

  function automatic sel_e decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    sel_e              s;
    off = a - IO_BASE;
    if ({1'b0, a} < DEPTH_L) begin
      s = SEL_RAM;
    end else if ((a >= IO_BASE) && (off < IO_SPAN)) begin
      case (off[3:0])
        IO_LED:  s = SEL_LED;
        IO_SW:   s = SEL_SW;
        IO_CNT:  s = SEL_CNT;
        default: s = SEL_UNMAP;
      endcase
    end else begin
      s = SEL_UNMAP;
    end
    return s;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic                ram_sel_q, ram_sel_d;
  logic [DATA_W-1:0]   io_rdata_q, io_rdata_d;
  logic [7:0]          led_q, led_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          sw_meta_q, sw_sync_q;

  logic                req_ready_s;
  logic                enter_resp_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic                cur_write_s;
  sel_e                cur_sel_s;
  sel_e                commit_sel_s;
  logic                commit_s;
  logic                ram_we_s;
  logic                ram_re_s;
  logic [DATA_W-1:0]   ram_rdata_s;

  // FSM next state, request latching and wait-state counting
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    wcnt_d       = wcnt_q;
    req_ready_s  = 1'b0;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_s = req_valid;
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            wcnt_d  = WC_LOAD;
          end else begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (wcnt_q == WC_ZERO) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WC_ONE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the request is still on the inputs when RESP is entered
  assign cur_addr_s  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_write_s = (state_q == IDLE) ? req_write : write_q;
  assign cur_sel_s   = decode(cur_addr_s);

  // response capture on entry to RESP
  always_comb begin
    resp_valid_d = enter_resp_s;
    resp_err_d   = 1'b0;
    ram_sel_d    = 1'b0;
    io_rdata_d   = DATA_Z;
    if (enter_resp_s) begin
      resp_err_d = (cur_sel_s == SEL_UNMAP) || ((cur_sel_s == SEL_SW) && cur_write_s);
      ram_sel_d  = (cur_sel_s == SEL_RAM) && !cur_write_s;
      if (!cur_write_s) begin
        case (cur_sel_s)
          SEL_LED: io_rdata_d = {EXT_Z, led_q};
          SEL_SW:  io_rdata_d = {EXT_Z, sw_sync_q};
          SEL_CNT: io_rdata_d = cnt_q;
          default: io_rdata_d = DATA_Z;
        endcase
      end else begin
        io_rdata_d = DATA_Z;
      end
    end else begin
      resp_err_d = 1'b0;
    end
  end

  assign ram_re_s     = enter_resp_s && (cur_sel_s == SEL_RAM) && !cur_write_s;
  assign commit_s     = (state_q == RESP) && write_q;
  assign commit_sel_s = decode(addr_q);
  assign ram_we_s     = commit_s && (commit_sel_s == SEL_RAM);

  // store commit into LED register; counter clear beats increment
  always_comb begin
    led_d = led_q;
    cnt_d = cnt_q + CNT_ONE;
    if (commit_s && (commit_sel_s == SEL_LED)) begin
      led_d = wdata_q[7:0];
    end else begin
      led_d = led_q;
    end
    if (commit_s && (commit_sel_s == SEL_CNT)) begin
      cnt_d = DATA_Z;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // state, latched request, response and I/O registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      write_q      <= 1'b0;
      wdata_q      <= DATA_Z;
      wcnt_q       <= WC_ZERO;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      ram_sel_q    <= 1'b0;
      io_rdata_q   <= DATA_Z;
      led_q        <= 8'h00;
      cnt_q        <= DATA_Z;
      sw_meta_q    <= 8'h00;
      sw_sync_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      wcnt_q       <= wcnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      ram_sel_q    <= ram_sel_d;
      io_rdata_q   <= io_rdata_d;
      led_q        <= led_d;
      cnt_q        <= cnt_d;
      sw_meta_q    <= sw_in;
      sw_sync_q    <= sw_meta_q;
    end
  end

  mem_ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (addr_q[RAM_AW-1:0]),
    .wdata (wdata_q),
    .re    (ram_re_s),
    .raddr (cur_addr_s[RAM_AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // ram_sel_q and io_rdata_q are only non-zero during the RESP cycle
  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = ram_sel_q ? ram_rdata_s : io_rdata_q;
  assign led_out    = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed and random load/store traffic against a
// behavioural memory/I-O model; instance 1 has one wait state, instance 0 none.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rv  [2];
  logic        rw  [2];
  logic [15:0] ra  [2];
  logic [15:0] rwd [2];
  logic        rr  [2];
  logic        vv  [2];
  logic [15:0] rdo [2];
  logic        eo  [2];
  logic [7:0]  sw  [2];
  logic [7:0]  led [2];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ram_m  [256];
  bit          ram_ok [256];
  logic [7:0]  led_m;
  logic [7:0]  sw_m;
  int          clr_base;
  bit          clr_ok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_ready(rr[1]), .resp_valid(vv[1]), .resp_rdata(rdo[1]),
    .resp_err(eo[1]), .sw_in(sw[1]), .led_out(led[1])
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_ready(rr[0]), .resp_valid(vv[0]), .resp_rdata(rdo[0]),
    .resp_err(eo[0]), .sw_in(sw[0]), .led_out(led[0])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full transaction; lat counts edges from the accept edge to the response cycle.
  task automatic do_req(input int d, input bit w, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output bit er, output int lat, output int rc);
    rv[d] = 1'b1; rw[d] = w; ra[d] = a; rwd[d] = wd;
    #1;
    chk("req_ready", {31'd0, rr[d]}, 32'd1);
    @(posedge clk); #1;
    rv[d] = 1'b0;
    lat = 1;
    while (!vv[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdo[d];
    er = eo[d];
    rc = cyc;
    step(1);
    chk("resp_pulse_width", {31'd0, vv[d]}, 32'd0);
    chk("rdata_zero_idle", {16'd0, rdo[d]}, 32'd0);
    chk("err_zero_idle", {31'd0, eo[d]}, 32'd0);
  endtask

  // Expected response from the memory map; rc is the cycle the response was seen.
  task automatic model(input bit w, input logic [15:0] a, input logic [15:0] wd, input int rc,
                       output logic [15:0] ed, output bit ee);
    ed = 16'h0000;
    ee = 1'b0;
    if (a < 16'd256) begin
      if (w) begin
        ram_m[a[7:0]]  = wd;
        ram_ok[a[7:0]] = 1'b1;
      end else begin
        ed = ram_m[a[7:0]];
      end
    end else if (a == 16'hFFF0) begin
      if (w) led_m = wd[7:0];
      else   ed = {8'h00, led_m};
    end else if (a == 16'hFFF1) begin
      if (w) ee = 1'b1;
      else   ed = {8'h00, sw_m};
    end else if (a == 16'hFFF2) begin
      if (w) begin
        clr_base = rc + 1;
        clr_ok   = 1'b1;
      end else begin
        ed = 16'(rc - 1 - clr_base);
      end
    end else begin
      ee = 1'b1;
    end
  endtask

  task automatic op1(input bit w, input logic [15:0] a, input logic [15:0] wd, input string tag);
    logic [15:0] rdv, ed;
    bit          erv, ee;
    int          lat, rc;
    do_req(1, w, a, wd, rdv, erv, lat, rc);
    model(w, a, wd, rc, ed, ee);
    chk({tag, "_latency"}, lat, 32'd2);
    chk({tag, "_rdata"}, {16'd0, rdv}, {16'd0, ed});
    chk({tag, "_err"}, {31'd0, erv}, {31'd0, ee});
    chk({tag, "_led"}, {24'd0, led[1]}, {24'd0, led_m});
  endtask

  initial begin
    logic [15:0] a, wd, rdv;
    bit          w, erv;
    int          cat, lat, rc, n;
    int          acc[$];

    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 16'h0; rwd[d] = 16'h0; sw[d] = 8'h00;
    end
    led_m = 8'h00; sw_m = 8'h00; clr_ok = 1'b0; clr_base = 0;

    step(3);
    chk("reset_resp_valid", {31'd0, vv[1]}, 32'd0);
    chk("reset_rdata", {16'd0, rdo[1]}, 32'd0);
    chk("reset_led", {24'd0, led[1]}, 32'd0);
    chk("reset_req_ready", {31'd0, rr[1]}, 32'd0);
    rst = 1'b1;
    step(1);

    op1(1'b1, 16'h0005, 16'hBEEF, "st5");
    op1(1'b0, 16'h0005, 16'h0000, "ld5");
    op1(1'b1, 16'h0010, 16'h1234, "st10");
    op1(1'b0, 16'h0010, 16'h0000, "ld10");

    op1(1'b1, 16'hFFF0, 16'hABCD, "st_led");
    op1(1'b0, 16'hFFF0, 16'h0000, "ld_led");
    sw_m = 8'h5A; sw[1] = sw_m;
    step(3);
    op1(1'b0, 16'hFFF1, 16'h0000, "ld_sw");
    op1(1'b1, 16'hFFF1, 16'h7777, "st_sw");

    op1(1'b1, 16'hFFF2, 16'h0000, "clr_cnt");
    step($urandom_range(0, 5));
    op1(1'b0, 16'hFFF2, 16'h0000, "ld_cnt");

    op1(1'b1, 16'h0000, 16'h4321, "st0");
    op1(1'b0, 16'h0100, 16'h0000, "ld_unmap");
    op1(1'b1, 16'h0100, 16'hDEAD, "st_unmap");
    op1(1'b0, 16'h0000, 16'h0000, "ld0_after_unmap");
    op1(1'b0, 16'hFFF5, 16'h0000, "ld_io_unmap");

    for (int i = 0; i < 30; i++) begin
      cat = $urandom_range(0, 9);
      w   = 1'($urandom_range(0, 1));
      wd  = 16'($urandom);
      case (cat)
        0, 1, 2, 3, 4: begin
          a = 16'($urandom_range(0, 255));
          if (!ram_ok[a[7:0]]) w = 1'b1;
        end
        5: a = 16'hFFF0;
        6: begin
          a = 16'hFFF1;
          if (!w) begin
            sw_m  = 8'($urandom);
            sw[1] = sw_m;
            step(3);
          end
        end
        7: begin
          a = 16'hFFF2;
          if (!clr_ok) w = 1'b1;
        end
        8: a = 16'($urandom_range(256, 16'hFFEF));
        default: a = 16'hFFF0 + 16'($urandom_range(3, 15));
      endcase
      op1(w, a, wd, "rnd");
    end

    do_req(0, 1'b1, 16'h0010, 16'h1234, rdv, erv, lat, rc);
    chk("w0_st_latency", lat, 32'd1);
    chk("w0_st_rdata", {16'd0, rdv}, 32'd0);
    do_req(0, 1'b0, 16'h0010, 16'h0000, rdv, erv, lat, rc);
    chk("w0_ld_latency", lat, 32'd1);
    chk("w0_ld_rdata", {16'd0, rdv}, 32'h1234);
    chk("w0_ld_err", {31'd0, erv}, 32'd0);

    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 16'h0005;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rr[1]) acc.push_back(cyc);
      @(posedge clk); #1;
    end
    rv[1] = 1'b0;
    step(4);
    chk("busy_accept_count", acc.size(), 32'd4);
    for (int i = 1; i < acc.size(); i++) begin
      chk("busy_accept_gap", acc[i] - acc[i-1], 32'd3);
    end

    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 16'h0005; rwd[1] = 16'h7777;
    #1;
    chk("rst_st_ready", {31'd0, rr[1]}, 32'd1);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_resp", {31'd0, vv[1]}, 32'd0);
      step(1);
    end
    rst = 1'b1;
    step(2);
    led_m = 8'h00; clr_ok = 1'b0;
    chk("post_rst_ready", {31'd0, rr[1]}, 32'd0);
    chk("post_rst_valid", {31'd0, vv[1]}, 32'd0);
    chk("post_rst_rdata", {16'd0, rdo[1]}, 32'd0);
    chk("post_rst_err", {31'd0, eo[1]}, 32'd0);
    chk("post_rst_led", {24'd0, led[1]}, 32'd0);
    op1(1'b0, 16'h0005, 16'h0000, "ld5_after_rst");

    op1(1'b1, 16'hFFF2, 16'h0000, "clr_wrap");
    n = 65535 + $urandom_range(0, 3);
    step(n);
    op1(1'b0, 16'hFFF2, 16'h0000, "ld_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
